var_state_mp: RTL and testbench
===============================

VAR_STATE_MP -- requirements
Module: var_state_mp

Interface
REQ-001 SHALL have parameter NUM_VARS, default 64: number of variable entries.
REQ-002 SHALL have parameter NUM_RD, default 5: number of combinational read ports (one per clause literal).
REQ-003 SHALL have parameter DL_BITS, default 6: decision-level width.
REQ-004 SHALL have parameter LANES, default 8: entries examined per sweep cycle; NUM_VARS SHALL be a multiple of LANES.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port wr_en, input, 1: write request.
REQ-008 SHALL have port wr_var, input, VAR_BITS=$clog2(NUM_VARS): write index.
REQ-009 SHALL have port wr_val, input, 1: value to assign.
REQ-010 SHALL have port wr_unassign, input, 1: 1 clears the entry instead of assigning it.
REQ-011 SHALL have port wr_level, input, DL_BITS: decision level stored with the assignment.
REQ-012 SHALL have port wr_ready, output, 1: write accepted this cycle.
REQ-013 SHALL have port rd_var, input, NUM_RD x VAR_BITS: read indices.
REQ-014 SHALL have port rd_val, output, NUM_RD: stored values.
REQ-015 SHALL have port rd_unassign, output, NUM_RD: 1 = unassigned.
REQ-016 SHALL have port rd_level, output, NUM_RD x DL_BITS: stored levels.
REQ-017 SHALL have port bt_start, input, 1: backtrack request.
REQ-018 SHALL have port bt_level, input, DL_BITS: backtrack target level.
REQ-019 SHALL have port bt_ready, output, 1: idle, able to accept bt_start.
REQ-020 SHALL have port bt_done, output, 1: one-cycle pulse when the sweep completes.
REQ-021 SHALL have port num_assigned, output, VAR_BITS+1: count of assigned entries.
REQ-022 SHALL have port all_assigned, output, 1: num_assigned == NUM_VARS.

Function
REQ-023 SHALL store per entry {unassign, val, level}, with unassigned meaning 1.
REQ-024 SHALL return each read port from registered state combinationally, with no write bypass; a write becomes visible the cycle after its clock edge.
REQ-025 SHALL return unassign=1, val=0, level=0 on a read whose index is >= NUM_VARS.
REQ-026 SHALL ignore a write whose index is >= NUM_VARS, with no counter change.
REQ-027 SHALL drive wr_ready=1 in IDLE; an accepted write stores {wr_unassign, wr_val, wr_level}.
REQ-028 SHALL apply num_assigned +1 on an unassigned->assigned transition, -1 on assigned->unassigned, and 0 on a rewrite of the same assigned/unassigned status.
REQ-029 SHALL use FSM states IDLE, SWEEP and DONE.
REQ-030 SHALL move IDLE->SWEEP on bt_start; bt_ready=1 only in IDLE.
REQ-031 SHALL latch bt_level on that transition.
REQ-032 SHALL, when wr_en and bt_start coincide in IDLE, accept both, applying the write first; the sweep then treats that entry normally.
REQ-033 SHALL, in SWEEP, examine entries [k*LANES, k*LANES+LANES-1] in cycle k, starting at k=0.
REQ-034 SHALL set unassign=1 on every examined assigned entry with level > latched bt_level, leaving val and level unchanged.
REQ-035 SHALL decrement num_assigned by the popcount of entries cleared in that cycle.
REQ-036 SHALL move SWEEP->DONE after chunk NUM_VARS/LANES-1, giving sweep length = NUM_VARS/LANES cycles.
REQ-037 SHALL assert bt_done for exactly one cycle in DONE, then return DONE->IDLE unconditionally.
REQ-038 SHALL hold wr_ready=0 in SWEEP and DONE; writes and bt_start SHALL be dropped there with no state change.
REQ-039 SHALL complete a sweep with bt_level >= every stored level clearing nothing.

Reset
REQ-040 SHALL, on reset low, asynchronously set all entries to {1,0,0}, FSM to IDLE, num_assigned=0, bt_done=0, wr_ready=1 and bt_ready=1 (while deasserted).
REQ-041 SHALL abort a sweep in progress on reset mid-sweep, with no bt_done.
REQ-042 SHALL accept no requests while reset is low.

Structure
REQ-043 SHALL place var_entry_t {unassign, val, level}, the FSM state enum and default constants in the shared sysdefs package.
REQ-044 SHALL implement per-cycle clear detection plus popcount as one sub-module, bt_sweep_lane, instantiated once over LANES entries.

Verification
REQ-045 SHALL cover reset then read of all ports: rd_unassign all 1, num_assigned=0, all_assigned=0.
REQ-046 SHALL cover write var 3, val=1, level=2: reads 0 cycles later show old state; 1 cycle later show {0,1,2}; num_assigned=1.
REQ-047 SHALL cover 64 vars assigned at levels 0..7 (var i at level i%8), then bt_start with bt_level=3: bt_done exactly 9 cycles after start (8 SWEEP + DONE), vars with level>3 unassigned, num_assigned=32.
REQ-048 SHALL cover a write during SWEEP: wr_ready=0, entry unchanged after bt_done.
REQ-049 SHALL cover reset asserted in the 4th SWEEP cycle: all entries unassigned, no bt_done, bt_ready=1 after release.
REQ-050 SHALL cover simultaneous write of var 5 at level 6 and bt_start with level 4 in IDLE: var 5 unassigned after the sweep, count consistent.

Source files
------------

// File: rtl/sysdefs.sv
// rtl/sysdefs.sv - shared types and defaults for the variable state memory
package sysdefs;

  localparam int DEF_NUM_VARS = 64;
  localparam int DEF_NUM_RD   = 5;
  localparam int DEF_DL_BITS  = 6;
  localparam int DEF_LANES    = 8;

  // One variable entry; unassign=1 means the variable has no value
  typedef struct packed {
    logic                   unassign;
    logic                   val;
    logic [DEF_DL_BITS-1:0] level;
  } var_entry_t;

  localparam var_entry_t ENTRY_RESET = '{unassign: 1'b1, val: 1'b0, level: '0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bt_sweep_lane.sv
// rtl/bt_sweep_lane.sv - per-chunk backtrack clear detection and popcount
module bt_sweep_lane #(
  parameter int LANES    = 8,
  parameter int DL_BITS  = 6,
  parameter int CNT_BITS = $clog2(LANES + 1)
) (
  input  logic                     en_i,
  input  logic [LANES-1:0]         unassign_i,
  input  logic [LANES*DL_BITS-1:0] level_i,
  input  logic [DL_BITS-1:0]       bt_level_i,
  output logic [LANES-1:0]         clr_o,
  output logic [CNT_BITS-1:0]      clr_cnt_o
);

  // An assigned entry above the target level gets cleared; count how many
  always_comb begin
    clr_o     = '0;
    clr_cnt_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (en_i && !unassign_i[l] && (level_i[l*DL_BITS +: DL_BITS] > bt_level_i)) begin
        clr_o[l]  = 1'b1;
        clr_cnt_o = clr_cnt_o + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/var_state_mp.sv
// rtl/var_state_mp.sv - multi-read-port variable assignment store with backtrack sweep
module var_state_mp
  import sysdefs::*;
#(
  parameter int  NUM_VARS = DEF_NUM_VARS,
  parameter int  NUM_RD   = DEF_NUM_RD,
  parameter int  DL_BITS  = DEF_DL_BITS,
  parameter int  LANES    = DEF_LANES,
  localparam int VAR_BITS = $clog2(NUM_VARS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [VAR_BITS-1:0]        wr_var,
  input  logic                       wr_val,
  input  logic                       wr_unassign,
  input  logic [DL_BITS-1:0]         wr_level,
  output logic                       wr_ready,
  input  logic [NUM_RD*VAR_BITS-1:0] rd_var,
  output logic [NUM_RD-1:0]          rd_val,
  output logic [NUM_RD-1:0]          rd_unassign,
  output logic [NUM_RD*DL_BITS-1:0]  rd_level,
  input  logic                       bt_start,
  input  logic [DL_BITS-1:0]         bt_level,
  output logic                       bt_ready,
  output logic                       bt_done,
  output logic [VAR_BITS:0]          num_assigned,
  output logic                       all_assigned
);

  localparam int CHUNKS     = NUM_VARS / LANES;
  localparam int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CNT_BITS   = $clog2(LANES + 1);
  localparam logic [VAR_BITS:0] NV = (VAR_BITS + 1)'(NUM_VARS);

  state_e                  state_q, state_d;
  logic [CHUNK_BITS-1:0]   chunk_q, chunk_d;
  logic [DL_BITS-1:0]      bt_level_q, bt_level_d;
  logic [VAR_BITS:0]       num_assigned_q, num_assigned_d;

  logic                    unassign_q [NUM_VARS];
  logic                    val_q      [NUM_VARS];
  logic [DL_BITS-1:0]      level_q    [NUM_VARS];

  logic                    wr_fire;
  logic [VAR_BITS-1:0]     lane_idx [LANES];
  logic [LANES-1:0]        lane_unassign;
  logic [LANES*DL_BITS-1:0] lane_level;
  logic [LANES-1:0]        lane_clr;
  logic [CNT_BITS-1:0]     lane_clr_cnt;

  // Writes are only taken while idle and only for indices that exist
  assign wr_fire      = (state_q == IDLE) && wr_en && ({1'b0, wr_var} < NV);
  assign wr_ready     = (state_q == IDLE);
  assign bt_ready     = (state_q == IDLE);
  assign bt_done      = (state_q == DONE);
  assign num_assigned = num_assigned_q;
  assign all_assigned = (num_assigned_q == NV);

  // Gather the chunk of entries examined this sweep cycle
  always_comb begin
    lane_unassign = '0;
    lane_level    = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]                      = VAR_BITS'(int'(chunk_q) * LANES + l);
      lane_unassign[l]                 = unassign_q[lane_idx[l]];
      lane_level[l*DL_BITS +: DL_BITS] = level_q[lane_idx[l]];
    end
  end

  bt_sweep_lane #(
    .LANES    (LANES),
    .DL_BITS  (DL_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_lane (
    .en_i       (state_q == SWEEP),
    .unassign_i (lane_unassign),
    .level_i    (lane_level),
    .bt_level_i (bt_level_q),
    .clr_o      (lane_clr),
    .clr_cnt_o  (lane_clr_cnt)
  );

  // Next-state logic for the backtrack sequencer
  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    bt_level_d = bt_level_q;
    case (state_q)
      IDLE: begin
        if (bt_start) begin
          state_d    = SWEEP;
          chunk_d    = '0;
          bt_level_d = bt_level;
        end
      end
      SWEEP: begin
        if (chunk_q == CHUNK_BITS'(CHUNKS - 1)) state_d = DONE;
        else                                     chunk_d = chunk_q + CHUNK_BITS'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Assigned-count tracks status transitions from writes and sweep clears
  always_comb begin
    num_assigned_d = num_assigned_q;
    if (wr_fire) begin
      if (unassign_q[wr_var] && !wr_unassign)      num_assigned_d = num_assigned_q + 1'b1;
      else if (!unassign_q[wr_var] && wr_unassign) num_assigned_d = num_assigned_q - 1'b1;
    end else if (state_q == SWEEP) begin
      num_assigned_d = num_assigned_q - (VAR_BITS + 1)'(lane_clr_cnt);
    end
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      chunk_q        <= '0;
      bt_level_q     <= '0;
      num_assigned_q <= '0;
    end else begin
      state_q        <= state_d;
      chunk_q        <= chunk_d;
      bt_level_q     <= bt_level_d;
      num_assigned_q <= num_assigned_d;
    end
  end

  // Entry storage: idle writes, sweep clears only the unassign bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        unassign_q[i] <= ENTRY_RESET.unassign;
        val_q[i]      <= ENTRY_RESET.val;
        level_q[i]    <= DL_BITS'(ENTRY_RESET.level);
      end
    end else begin
      if (wr_fire) begin
        unassign_q[wr_var] <= wr_unassign;
        val_q[wr_var]      <= wr_val;
        level_q[wr_var]    <= wr_level;
      end
      for (int l = 0; l < LANES; l++) begin
        if (lane_clr[l]) unassign_q[lane_idx[l]] <= 1'b1;
      end
    end
  end

  // Combinational read ports straight from stored state
  always_comb begin
    rd_val      = '0;
    rd_unassign = '1;
    rd_level    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ({1'b0, rd_var[p*VAR_BITS +: VAR_BITS]} < NV) begin
        rd_unassign[p]                 = unassign_q[rd_var[p*VAR_BITS +: VAR_BITS]];
        rd_val[p]                      = val_q[rd_var[p*VAR_BITS +: VAR_BITS]];
        rd_level[p*DL_BITS +: DL_BITS] = level_q[rd_var[p*VAR_BITS +: VAR_BITS]];
      end
    end
  end

endmodule

// File: tb/tb_var_state_mp.sv
// tb/tb_var_state_mp.sv - self-checking bench for var_state_mp
module tb_var_state_mp;

  localparam int NV = 64;
  localparam int NR = 5;
  localparam int DL = 6;
  localparam int VB = 6;

  logic           clock = 1'b0;
  logic           reset;
  logic           wr_en, wr_val, wr_unassign;
  logic [VB-1:0]  wr_var;
  logic [DL-1:0]  wr_level;
  logic           wr_ready;
  logic [NR*VB-1:0] rd_var;
  logic [NR-1:0]  rd_val, rd_unassign;
  logic [NR*DL-1:0] rd_level;
  logic           bt_start;
  logic [DL-1:0]  bt_level;
  logic           bt_ready, bt_done;
  logic [VB:0]    num_assigned;
  logic           all_assigned;

  int tests = 0;
  int fails = 0;

  bit m_u [NV];
  bit m_v [NV];
  int m_l [NV];

  always #5 clock = ~clock;

  var_state_mp dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_var(wr_var), .wr_val(wr_val), .wr_unassign(wr_unassign),
    .wr_level(wr_level), .wr_ready(wr_ready),
    .rd_var(rd_var), .rd_val(rd_val), .rd_unassign(rd_unassign), .rd_level(rd_level),
    .bt_start(bt_start), .bt_level(bt_level), .bt_ready(bt_ready), .bt_done(bt_done),
    .num_assigned(num_assigned), .all_assigned(all_assigned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NV; i++) if (!m_u[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin m_u[i] = 1; m_v[i] = 0; m_l[i] = 0; end
  endtask

  task automatic model_backtrack(input int lvl);
    for (int i = 0; i < NV; i++) if (!m_u[i] && m_l[i] > lvl) m_u[i] = 1;
  endtask

  // one idle write; caller is at posedge+1
  task automatic do_write(input int v, input bit val, input bit un, input int lvl);
    wr_en = 1; wr_var = VB'(v); wr_val = val; wr_unassign = un; wr_level = DL'(lvl);
    @(posedge clock); #1;
    wr_en = 0;
    m_u[v] = un; m_v[v] = val; m_l[v] = lvl;
  endtask

  task automatic check_all(input string tag);
    for (int b = 0; b < NV; b += NR) begin
      for (int p = 0; p < NR; p++) rd_var[p*VB +: VB] = VB'((b + p) % NV);
      #1;
      for (int p = 0; p < NR; p++) begin
        int v = (b + p) % NV;
        check({tag, "_u"}, 32'(rd_unassign[p]), 32'(m_u[v]));
        check({tag, "_v"}, 32'(rd_val[p]), 32'(m_v[v]));
        check({tag, "_l"}, 32'(rd_level[p*DL +: DL]), 32'(m_l[v]));
      end
    end
    check({tag, "_cnt"}, 32'(num_assigned), 32'(model_count()));
    check({tag, "_all"}, 32'(all_assigned), 32'(model_count() == NV));
  endtask

  // start a backtrack; returns the cycle (1 = start edge) at which bt_done is seen
  task automatic run_bt(input int lvl, output int cyc);
    bt_start = 1; bt_level = DL'(lvl);
    @(posedge clock); #1;
    bt_start = 0;
    cyc = 1;
    while (bt_done !== 1'b1 && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    reset = 0; wr_en = 0; wr_var = 0; wr_val = 0; wr_unassign = 0; wr_level = 0;
    rd_var = '0; bt_start = 0; bt_level = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_bt_ready", 32'(bt_ready), 1);
    check("rst_bt_done", 32'(bt_done), 0);
    reset = 1;
    @(posedge clock); #1;
    check_all("reset");

    // write var 3 and observe no bypass, then the stored value
    rd_var[0 +: VB] = 3;
    wr_en = 1; wr_var = 3; wr_val = 1; wr_unassign = 0; wr_level = 2;
    #1;
    check("w3_ready", 32'(wr_ready), 1);
    check("w3_old_u", 32'(rd_unassign[0]), 1);
    check("w3_old_l", 32'(rd_level[0 +: DL]), 0);
    @(posedge clock); #1;
    wr_en = 0;
    m_u[3] = 0; m_v[3] = 1; m_l[3] = 2;
    check("w3_new_u", 32'(rd_unassign[0]), 0);
    check("w3_new_v", 32'(rd_val[0]), 1);
    check("w3_new_l", 32'(rd_level[0 +: DL]), 2);
    check("w3_cnt", 32'(num_assigned), 1);

    // random writes including rewrites and unassigns
    for (int i = 0; i < 60; i++) begin
      do_write($urandom_range(0, NV-1), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 63));
      check("rnd_cnt", 32'(num_assigned), 32'(model_count()));
    end
    check_all("rnd");

    // full assignment at level i%8, then backtrack to 3
    for (int i = 0; i < NV; i++) do_write(i, 1'($urandom), 0, i % 8);
    check("full_all", 32'(all_assigned), 1);
    check("full_cnt", 32'(num_assigned), NV);
    run_bt(3, cyc);
    model_backtrack(3);
    check("bt3_latency", 32'(cyc), 9);
    check("bt3_wr_ready", 32'(wr_ready), 0);
    check("bt3_bt_ready", 32'(bt_ready), 0);
    @(posedge clock); #1;
    check("bt3_done_pulse", 32'(bt_done), 0);
    check("bt3_idle", 32'(bt_ready), 1);
    check("bt3_cnt", 32'(num_assigned), 32);
    check_all("bt3");

    // write and bt_start during SWEEP are dropped
    bt_start = 1; bt_level = 0;
    @(posedge clock); #1;
    cyc = 1;
    wr_en = 1; wr_var = 0; wr_val = ~m_v[0]; wr_unassign = 1; wr_level = 5;
    bt_start = 1; bt_level = 0;
    #1;
    check("sw_wr_ready", 32'(wr_ready), 0);
    while (bt_done !== 1'b1 && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
    end
    wr_en = 0; bt_start = 0;
    model_backtrack(0);
    check("sw_latency", 32'(cyc), 9);
    @(posedge clock); #1;
    check("sw_no_restart", 32'(bt_ready), 1);
    check_all("sw");

    // coincident write of var 5 at level 6 and bt_start at level 4
    wr_en = 1; wr_var = 5; wr_val = 1; wr_unassign = 0; wr_level = 6;
    m_u[5] = 0; m_v[5] = 1; m_l[5] = 6;
    run_bt(4, cyc);
    wr_en = 0;
    model_backtrack(4);
    check("co_latency", 32'(cyc), 9);
    @(posedge clock); #1;
    rd_var[0 +: VB] = 5;
    #1;
    check("co_v5_u", 32'(rd_unassign[0]), 1);
    check_all("co");

    // random write bursts followed by random backtracks
    for (int r = 0; r < 4; r++) begin
      int lvl;
      for (int i = 0; i < 30; i++)
        do_write($urandom_range(0, NV-1), 1'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 63));
      lvl = $urandom_range(0, 63);
      run_bt(lvl, cyc);
      model_backtrack(lvl);
      check("rbt_latency", 32'(cyc), 9);
      @(posedge clock); #1;
      check_all("rbt");
    end

    // greater-or-equal target clears nothing
    run_bt(63, cyc);
    check("bt63_latency", 32'(cyc), 9);
    @(posedge clock); #1;
    check_all("bt63");

    // reset in the 4th SWEEP cycle aborts the sweep
    for (int i = 0; i < 16; i++) do_write(i, 1, 0, 10 + i);
    bt_start = 1; bt_level = 0;
    @(posedge clock); #1;
    bt_start = 0;
    repeat (3) @(posedge clock);
    #2;
    reset = 0;
    model_reset();
    #1;
    check("mid_rst_cnt", 32'(num_assigned), 0);
    check("mid_rst_done", 32'(bt_done), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (bt_done === 1'b1) cyc++;
    end
    check("mid_rst_no_done", 32'(cyc), 0);
    check("mid_rst_bt_ready", 32'(bt_ready), 1);
    check_all("mid_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
